hamming_enc_pipe: RTL and testbench

- Parametrised pipelined Hamming encoder; the next generation of the fixed 16->21 bit encoder.
- Supports any data width and an optional SECDED overall-parity bit.
- Uses a full valid/ready stream handshake with backpressure and full throughput, instead of edge-detected pulses.
- Adds a per-word error-injection path and a transfer counter for decoder verification; sits between the packet framer and the serialiser.

---
 rtl/hamming_enc_pipe_pkg.sv | 55 +++++
 rtl/hamming_enc_pipe_if.sv | 34 +++
 rtl/hamming_enc_pipe_inj.sv | 30 +++
 rtl/hamming_enc_pipe.sv | 98 +++++++++
 tb/tb_hamming_enc_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_enc_pipe_pkg.sv
// Shared Hamming code helpers: parity-count sizing and a golden encoder.
// Both the pipelined encoder and the future decoder use these functions.
package hamming_pkg;

  // Widest codeword the helpers handle (DATA_W=57, SECDED=1 -> 64 bits).
  localparam int MAX_CODE_W = 64;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int hamming_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  // True when x is a power of two, i.e. x is a parity position.
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Places data LSB-first into non-power-of-two positions, then fills the
  // parity positions with even parity and optionally the overall parity bit.
  function automatic logic [MAX_CODE_W-1:0] hamming_encode(
    input logic [MAX_CODE_W-1:0] data,
    input int                    data_w,
    input bit                    secded
  );
    logic [MAX_CODE_W-1:0] cw;
    logic [5:0]            di;
    logic                  par;
    int                    p;
    cw = '0;
    di = '0;
    p  = hamming_p(data_w);
    for (int i = 0; i < MAX_CODE_W; i++) begin
      if ((i < data_w + p) && !is_pow2(i + 1)) begin
        cw[6'(i)] = data[di];
        di        = di + 6'd1;
      end
    end
    for (int k = 0; k < 7; k++) begin
      if (k < p) begin
        par = 1'b0;
        for (int i = 0; i < MAX_CODE_W; i++) begin
          if ((i < data_w + p) && !is_pow2(i + 1) && ((((i + 1) >> k) & 1) == 1))
            par = par ^ cw[6'(i)];
        end
        cw[6'((1 << k) - 1)] = par;
      end
    end
    if (secded) cw[6'(data_w + p)] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_enc_pipe_if.sv
// Stream bundle for the Hamming encoder: upstream word + injection controls,
// downstream codeword, and the valid/ready pairs in both directions.
interface hamming_enc_pipe_if #(
  parameter int DATA_W = 16,
  parameter int SECDED = 1
);
  import hamming_pkg::*;

  localparam int CODE_W = DATA_W + hamming_p(DATA_W) + SECDED;
  localparam int POS_W  = $clog2(CODE_W);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic              inj_en;
  logic [POS_W-1:0]  inj_pos;
  logic              inj_double;
  logic [CODE_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  // Environment side: produces words, consumes codewords.
  modport master (
    output i_data, i_valid, inj_en, inj_pos, inj_double, i_ready,
    input  o_ready, o_data, o_valid
  );

  // Encoder side.
  modport slave (
    input  i_data, i_valid, inj_en, inj_pos, inj_double, i_ready,
    output o_ready, o_data, o_valid
  );

endinterface

// File: rtl/hamming_enc_pipe_inj.sv
// Combinational error injector: flips one codeword bit, optionally also the
// next bit (wrapping to bit 0). Out-of-range positions leave the word intact.
module hamming_inj #(
  parameter int CODE_W = 22,
  parameter int POS_W  = 5
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic              en_i,
  input  logic [POS_W-1:0]  pos_i,
  input  logic              double_i,
  output logic [CODE_W-1:0] code_o
);

  logic [CODE_W-1:0] mask;
  logic [POS_W-1:0]  pos_nxt;
  logic              in_range;

  // Build the flip mask from position, wrap-around neighbour and enables.
  always_comb begin
    in_range = int'(pos_i) < CODE_W;
    pos_nxt  = (int'(pos_i) == CODE_W - 1) ? '0 : pos_i + 1'b1;
    mask     = '0;
    if (en_i && in_range) begin
      mask = CODE_W'(1) << pos_i;
      if (double_i) mask = mask | (CODE_W'(1) << pos_nxt);
    end
    code_o = code_i ^ mask;
  end

endmodule

// File: rtl/hamming_enc_pipe.sv
// Two-stage pipelined Hamming/SECDED encoder with valid/ready backpressure,
// per-word error injection and a wrapping count of delivered codewords.
module hamming_enc_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  hamming_enc_pipe_if.slave bus,
  output logic [CNT_W-1:0]  o_word_cnt
);

  localparam int CODE_W = DATA_W + hamming_p(DATA_W) + SECDED;
  localparam int POS_W  = $clog2(CODE_W);

  logic              vld_p1_q;
  logic              vld_p2_q;
  logic [DATA_W-1:0] data_p1_q;
  logic              inj_en_p1_q;
  logic [POS_W-1:0]  inj_pos_p1_q;
  logic              inj_dbl_p1_q;
  logic [CODE_W-1:0] enc_p1;
  logic [CODE_W-1:0] code_p2_d;
  logic [CODE_W-1:0] code_p2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s1_adv;
  logic              s2_adv;
  logic              accept;

  // A stage may load when it is empty or its content moves on this cycle;
  // o_ready depends only on occupancy and i_ready, never on i_valid.
  assign s2_adv = !vld_p2_q || bus.i_ready;
  assign s1_adv = !vld_p1_q || s2_adv;
  assign accept = bus.i_valid && s1_adv;

  assign bus.o_ready = s1_adv;
  assign bus.o_valid = vld_p2_q;
  assign bus.o_data  = code_p2_q;
  assign o_word_cnt  = cnt_q;

  // Parity generation on the S1 word; injection is applied afterwards so it
  // can never disturb the parity bits that were computed.
  assign enc_p1 = CODE_W'(hamming_encode(MAX_CODE_W'(data_p1_q), DATA_W, SECDED != 0));

  hamming_inj #(
    .CODE_W (CODE_W),
    .POS_W  (POS_W)
  ) u_inj (
    .code_i   (enc_p1),
    .en_i     (inj_en_p1_q),
    .pos_i    (inj_pos_p1_q),
    .double_i (inj_dbl_p1_q),
    .code_o   (code_p2_d)
  );

  // Stage occupancy flags; reset discards any in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (s1_adv) vld_p1_q <= bus.i_valid;
      if (s2_adv) vld_p2_q <= vld_p1_q;
    end
  end

  // ---- S1: capture data word and injection controls on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1_q    <= bus.i_data;
      inj_en_p1_q  <= bus.inj_en;
      inj_pos_p1_q <= bus.inj_pos;
      inj_dbl_p1_q <= bus.inj_double;
    end
  end

  // ---- S2: register encoded (and possibly corrupted) codeword ----
  always_ff @(posedge clk) begin
    if (rst) begin
      code_p2_q <= '0;
    end else if (s2_adv && vld_p1_q) begin
      code_p2_q <= code_p2_d;
    end
  end

  // Count completed downstream transfers, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (vld_p2_q && bus.i_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_enc_pipe.sv
// Bench for hamming_enc_pipe: a SECDED build, a plain-Hamming build and a
// 4-bit-counter build share one stimulus stream; a syndrome-style reference
// model and an ordered scoreboard judge every delivered codeword.
module tb_hamming_enc_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_enc_pipe_if #(.DATA_W(16), .SECDED(1)) bus0 ();
  hamming_enc_pipe_if #(.DATA_W(16), .SECDED(0)) bus1 ();
  hamming_enc_pipe_if #(.DATA_W(16), .SECDED(1)) bus2 ();

  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  assign bus1.i_data     = bus0.i_data;
  assign bus1.i_valid    = bus0.i_valid;
  assign bus1.inj_en     = bus0.inj_en;
  assign bus1.inj_pos    = bus0.inj_pos;
  assign bus1.inj_double = bus0.inj_double;
  assign bus1.i_ready    = bus0.i_ready;
  assign bus2.i_data     = bus0.i_data;
  assign bus2.i_valid    = bus0.i_valid;
  assign bus2.inj_en     = bus0.inj_en;
  assign bus2.inj_pos    = bus0.inj_pos;
  assign bus2.inj_double = bus0.inj_double;
  assign bus2.i_ready    = bus0.i_ready;

  hamming_enc_pipe #(.DATA_W(16), .SECDED(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .o_word_cnt(cnt0));
  hamming_enc_pipe #(.DATA_W(16), .SECDED(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .o_word_cnt(cnt1));
  hamming_enc_pipe #(.DATA_W(16), .SECDED(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .o_word_cnt(cnt2));

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct packed {
    logic [15:0] d;
    logic        en;
    logic [4:0]  pos;
    logic        dbl;
  } txn_t;
  txn_t sbq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: data fills non-power-of-two positions 1..21 in order; the
  // parity bits together equal the XOR of the positions holding a 1.
  function automatic logic [21:0] ref_enc(input logic [15:0] d, input bit secded,
                                          input logic en, input logic [4:0] pos, input logic dbl);
    logic [21:0] cw;
    int syn, n, len, p2;
    cw = '0; syn = 0; n = 0;
    len = secded ? 22 : 21;
    for (int q = 1; q <= 21; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (((d >> n) & 16'd1) != 16'd0) begin
          cw  = cw | (22'd1 << (q - 1));
          syn = syn ^ q;
        end
        n++;
      end
    end
    for (int k = 0; k < 5; k++)
      if (((syn >> k) & 1) == 1) cw = cw | (22'd1 << ((1 << k) - 1));
    if (secded && (^cw[20:0])) cw = cw | (22'd1 << 21);
    if (en && (int'(pos) < len)) begin
      cw = cw ^ (22'd1 << pos);
      if (dbl) begin
        p2 = (int'(pos) + 1) % len;
        cw = cw ^ (22'd1 << p2);
      end
    end
    return cw;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  initial begin
    txn_t        t;
    txn_t        nt;
    logic [21:0] prev_data;
    logic        prev_stall;
    prev_data = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        exp_cnt = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_valid", 64'(bus0.o_valid), 64'd1);
          check_eq("stall_data", 64'(bus0.o_data), 64'(prev_data));
        end
        if (bus0.o_valid && bus0.i_ready) begin
          exp_cnt = exp_cnt + 16'd1;
          n_out++;
          if (sbq.size() == 0) begin
            check_eq("spurious_out", 64'(bus0.o_valid), 64'd0);
          end else begin
            t = sbq.pop_front();
            check_eq("enc_secded", 64'(bus0.o_data), 64'(ref_enc(t.d, 1'b1, t.en, t.pos, t.dbl)));
            check_eq("enc_plain", 64'(bus1.o_data), 64'(ref_enc(t.d, 1'b0, t.en, t.pos, t.dbl)));
            if (!t.en) check_eq("even_weight", 64'(^bus0.o_data), 64'd0);
          end
        end
        if (bus0.i_valid && bus0.o_ready) begin
          nt.d = bus0.i_data; nt.en = bus0.inj_en;
          nt.pos = bus0.inj_pos; nt.dbl = bus0.inj_double;
          sbq.push_back(nt);
        end
        prev_stall = bus0.o_valid && !bus0.i_ready;
        prev_data = bus0.o_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus0.i_valid = 1'b0;
    bus0.i_data = '0;
    bus0.inj_en = 1'b0;
    bus0.inj_pos = '0;
    bus0.inj_double = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    check_eq("rst_valid", 64'(bus0.o_valid), 64'd0);
    check_eq("rst_cnt", 64'(cnt0), 64'd0);
    check_eq("rst_ready", 64'(bus0.o_ready), 64'd1);
    rst = 1'b0;
  endtask

  // Single word into an empty pipe with i_ready high; checks latency and value.
  task automatic directed(input string tag, input logic [15:0] d, input logic en,
                          input logic [4:0] pos, input logic dbl, input logic [21:0] exp);
    bus0.i_data = d; bus0.i_valid = 1'b1;
    bus0.inj_en = en; bus0.inj_pos = pos; bus0.inj_double = dbl;
    tick();
    drive_idle();
    check_eq({tag, "_early"}, 64'(bus0.o_valid), 64'd0);
    tick();
    check_eq({tag, "_valid"}, 64'(bus0.o_valid), 64'd1);
    check_eq({tag, "_data"}, 64'(bus0.o_data), 64'(exp));
    tick();
  endtask

  initial begin
    int  idx, cyc, base;
    bit  dropped, go;
    drive_idle();
    bus0.i_ready = 1'b1;
    repeat (2) tick();
    check_eq("rst_data", 64'(bus0.o_data), 64'd0);
    do_reset();

    directed("d0001", 16'h0001, 1'b0, 5'd0, 1'b0, 22'h200007);
    check_eq("legacy_0001", 64'(bus1.o_data), 64'h000007);
    directed("dffff", 16'hFFFF, 1'b0, 5'd0, 1'b0, 22'h1FFFFE);
    directed("d0000", 16'h0000, 1'b0, 5'd0, 1'b0, 22'h000000);
    directed("inj5", 16'h0000, 1'b1, 5'd5, 1'b0, 22'h000020);
    directed("inj5dbl", 16'h0000, 1'b1, 5'd5, 1'b1, 22'h000060);
    directed("injwrap", 16'h0000, 1'b1, 5'd21, 1'b1, 22'h200001);
    directed("injoor", 16'h0000, 1'b1, 5'd25, 1'b0, 22'h000000);

    // Backpressure: i_ready low for the first 5 cycles of an 8-word stream.
    do_reset();
    idx = 0; cyc = 0; dropped = 1'b0;
    while (idx < 8 && cyc < 60) begin
      bus0.i_valid = 1'b1;
      bus0.i_data = 16'hA500 + 16'(idx);
      bus0.i_ready = (cyc >= 5);
      @(negedge clk);
      if (!dropped && !bus0.o_ready) begin
        dropped = 1'b1;
        check_eq("bp_ready_drop", 64'(idx), 64'd2);
      end
      go = bus0.o_ready;
      tick();
      if (go) idx++;
      cyc++;
    end
    check_eq("bp_all_accepted", 64'(idx), 64'd8);
    check_eq("bp_saw_drop", 64'(dropped), 64'd1);
    drive_idle();
    bus0.i_ready = 1'b1;
    repeat (4) tick();
    check_eq("bp_count", 64'(cnt0), 64'd8);
    check_eq("bp_drained", 64'(sbq.size()), 64'd0);

    // Full throughput: 100 words back to back.
    base = n_out;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        bus0.i_valid = 1'b1;
        bus0.i_data = 16'($urandom);
      end else begin
        drive_idle();
      end
      tick();
    end
    check_eq("thru_count", 64'(n_out - base), 64'd100);

    // Random valid/ready/injection mix.
    for (int i = 0; i < 300; i++) begin
      bus0.i_valid = ($urandom_range(0, 3) != 0);
      bus0.i_ready = ($urandom_range(0, 3) != 0);
      bus0.i_data = 16'($urandom);
      bus0.inj_en = ($urandom_range(0, 3) == 0);
      bus0.inj_pos = 5'($urandom_range(0, 31));
      bus0.inj_double = 1'($urandom_range(0, 1));
      tick();
    end
    drive_idle();
    bus0.i_ready = 1'b1;
    repeat (4) tick();
    check_eq("rand_drained", 64'(sbq.size()), 64'd0);
    check_eq("rand_cnt16", 64'(cnt0), 64'(exp_cnt));
    check_eq("rand_cnt4", 64'(cnt2), 64'(exp_cnt[3:0]));

    // Reset with both stages full.
    bus0.i_ready = 1'b0;
    bus0.i_valid = 1'b1;
    bus0.i_data = 16'h1234;
    tick();
    bus0.i_data = 16'h5678;
    tick();
    drive_idle();
    check_eq("full_ready", 64'(bus0.o_ready), 64'd0);
    check_eq("full_valid", 64'(bus0.o_valid), 64'd1);
    do_reset();
    bus0.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("no_stale", 64'(bus0.o_valid), 64'd0);
    end

    // Counter wrap on the 4-bit build: 17 transfers.
    do_reset();
    bus0.i_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus0.i_valid = 1'b1;
      bus0.i_data = 16'($urandom);
      tick();
    end
    drive_idle();
    repeat (3) tick();
    check_eq("wrap_cnt4", 64'(cnt2), 64'd1);
    check_eq("wrap_cnt16", 64'(cnt0), 64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
